// File: rtl/fp_pkg.sv
// Shared floating-point adder definitions: comparator codes, align FSM encoding, GRS width.
package fp_pkg;

    localparam logic [1:0] EQUAL = 2'b00;
    localparam logic [1:0] GREAT = 2'b01;  // exp_A < exp_B, so B is the larger operand
    localparam logic [1:0] SMALL = 2'b10;

    localparam int GRS_BITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sticky_shift.sv
// Single-step combinational right shift by 0..2**AW-1 bits.
// With ALIGN_STICKY_EN defined, every bit shifted out (including the old bit 0) is OR-folded into bit 0.
module sticky_shift #(
    parameter int W  = 27,
    parameter int AW = 5
) (
    input  logic [W-1:0]  data,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  result
);

    logic [W-1:0] shifted;

    assign shifted = data >> amt;

`ifdef ALIGN_STICKY_EN
    logic [W-1:0] lost_mask;
    logic         lost;

    // Shift amounts of W or more give a zero left shift, so the mask covers the whole word.
    assign lost_mask = ~({W{1'b1}} << amt);
    assign lost      = |(data & lost_mask);
    assign result    = {shifted[W-1:1], shifted[0] | lost};
`else
    assign result = shifted;
`endif

endmodule

// File: rtl/exp_align.sv
// Exponent-alignment stage: shifts the smaller mantissa right by the exponent difference,
// SHIFT_STEP bits per cycle. Optional sticky accumulation is enabled by ALIGN_STICKY_EN.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANT_SIZE
`define MANT_SIZE 23
`endif

// Handshakes: a transfer happens on a rising edge where both valid and ready are high.
// Upstream: in_valid/out_ready. Downstream: out_valid/in_ready; outputs hold while out_valid && !in_ready.
module exp_align
    import fp_pkg::*;
#(
    parameter int EXP_SIZE   = `EXP_SIZE,
    parameter int MANT_SIZE  = `MANT_SIZE,
    parameter int SHIFT_STEP = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [1:0]            in_code,
    input  logic [EXP_SIZE-1:0]   in_exp_A,
    input  logic [EXP_SIZE-1:0]   in_exp_B,
    input  logic [MANT_SIZE:0]    in_mant_A,
    input  logic [MANT_SIZE:0]    in_mant_B,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [EXP_SIZE-1:0]   out_exp,
    output logic                  out_swap,
    output logic [MANT_SIZE+3:0]  out_mant_big,
    output logic [MANT_SIZE+3:0]  out_mant_small,
    output state_t                out_state
);

    localparam int MW = MANT_SIZE + 1;
    localparam int FW = MW + GRS_BITS;
    localparam int RW = $clog2(FW + 1);
    localparam logic [RW-1:0] STEP_R = RW'(SHIFT_STEP);
`ifdef ALIGN_STICKY_EN
    localparam int SRW = FW;
`else
    localparam int SRW = MW;
`endif

    state_t              state, state_nx;
    logic                accept;
    logic [EXP_SIZE-1:0] exp_big, exp_small, diff;
    logic [MW-1:0]       mant_big_in, mant_small_in;
    logic [RW-1:0]       diff_c, step_k, rem_r;
    logic [EXP_SIZE-1:0] exp_r;
    logic                swap_r;
    logic [MW-1:0]       big_r;
    logic [SRW-1:0]      small_r, small_load, shift_out;

    // Code 11 falls into the A-is-larger branch together with 10.
    always_comb begin
        exp_big       = in_exp_A;
        exp_small     = in_exp_B;
        mant_big_in   = in_mant_A;
        mant_small_in = in_mant_B;
        if (in_code == GREAT) begin
            exp_big       = in_exp_B;
            exp_small     = in_exp_A;
            mant_big_in   = in_mant_B;
            mant_small_in = in_mant_A;
        end
        diff = (in_code == EQUAL) ? '0 : exp_big - exp_small;
        if (int'(diff) > FW) diff_c = RW'(FW);
        else                 diff_c = RW'(diff);
    end

`ifdef ALIGN_STICKY_EN
    assign small_load = {mant_small_in, {GRS_BITS{1'b0}}};
`else
    assign small_load = mant_small_in;
`endif

    assign step_k = (rem_r > STEP_R) ? STEP_R : rem_r;

    sticky_shift #(
        .W  (SRW),
        .AW (RW)
    ) u_shift (
        .data   (small_r),
        .amt    (step_k),
        .result (shift_out)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        out_ready = (state == IDLE) && !in_rst;
        out_valid = (state == DONE);
        accept    = in_valid && out_ready;
        case (state)
            IDLE:    if (accept) state_nx = (diff_c == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_r <= STEP_R) state_nx = DONE;
            DONE:    if (in_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            exp_r   <= '0;
            swap_r  <= 1'b0;
            big_r   <= '0;
            small_r <= '0;
            rem_r   <= '0;
        end else if (accept) begin
            exp_r   <= exp_big;
            swap_r  <= (in_code == GREAT);
            big_r   <= mant_big_in;
            small_r <= small_load;
            rem_r   <= diff_c;
        end else if (state == SHIFT) begin
            small_r <= shift_out;
            rem_r   <= rem_r - step_k;
        end
    end

    assign out_exp      = exp_r;
    assign out_swap     = swap_r;
    assign out_mant_big = {big_r, {GRS_BITS{1'b0}}};
`ifdef ALIGN_STICKY_EN
    assign out_mant_small = small_r;
`else
    assign out_mant_small = {small_r, {GRS_BITS{1'b0}}};
`endif
    assign out_state = state;

endmodule

// File: tb/tb_exp_align.sv
// Self-checking bench for exp_align (default parameters): vector table, random vectors,
// backpressure and mid-operation reset sequences. Honours ALIGN_STICKY_EN.
module tb_exp_align;
    import fp_pkg::*;

    typedef struct {
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [1:0]  code;
        logic [23:0] mant_a;
        logic [23:0] mant_b;
        logic [7:0]  e_exp;
        logic        e_swap;
        logic [26:0] e_big;
        logic [26:0] e_small;
        int          e_lat;
    } vec_t;

    logic        in_clk = 1'b0;
    logic        in_rst, in_valid, in_ready;
    logic        out_ready, out_valid, out_swap;
    logic [1:0]  in_code;
    logic [7:0]  in_exp_A, in_exp_B, out_exp;
    logic [23:0] in_mant_A, in_mant_B;
    logic [26:0] out_mant_big, out_mant_small;
    state_t      dbg_state;

    int checks = 0;
    int passes = 0;
    logic [62:0] exp_q[$];
    int          lat_q[$];
    vec_t        tbl[8];

    exp_align dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_code        (in_code),
        .in_exp_A       (in_exp_A),
        .in_exp_B       (in_exp_B),
        .in_mant_A      (in_mant_A),
        .in_mant_B      (in_mant_B),
        .out_valid      (out_valid),
        .in_ready       (in_ready),
        .out_exp        (out_exp),
        .out_swap       (out_swap),
        .out_mant_big   (out_mant_big),
        .out_mant_small (out_mant_small),
        .out_state      (dbg_state)
    );

    // clock / watchdog
    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] c,
                                input logic [23:0] ma, input logic [23:0] mb, input logic [7:0] ee,
                                input logic es, input logic [26:0] eg, input logic [26:0] s_sticky,
                                input logic [26:0] s_trunc, input int lat);
        vec_t v;
        v.exp_a = ea; v.exp_b = eb; v.code = c; v.mant_a = ma; v.mant_b = mb;
        v.e_exp = ee; v.e_swap = es; v.e_big = eg; v.e_lat = lat;
`ifdef ALIGN_STICKY_EN
        v.e_small = s_sticky;
`else
        v.e_small = s_trunc;
`endif
        return v;
    endfunction

    // Reference: one-shot wide shift of the full operand.
    function automatic vec_t model(input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] c,
                                   input logic [23:0] ma, input logic [23:0] mb);
        vec_t v;
        int d;
        logic [63:0] full, res;
        logic [23:0] ms;
        v.exp_a = ea; v.exp_b = eb; v.code = c; v.mant_a = ma; v.mant_b = mb;
        if (c == 2'b01) begin
            v.e_exp = eb; v.e_swap = 1'b1; v.e_big = {mb, 3'b000}; ms = ma; d = int'(eb) - int'(ea);
        end else begin
            v.e_exp = ea; v.e_swap = 1'b0; v.e_big = {ma, 3'b000}; ms = mb; d = int'(ea) - int'(eb);
        end
        if (c == 2'b00) d = 0;
        if (d > 27) d = 27;
`ifdef ALIGN_STICKY_EN
        full = {40'd0, ms, 3'b000};
        res  = full >> d;
        if ((full & ((64'd1 << d) - 64'd1)) != 64'd0) res[0] = 1'b1;
`else
        full = {40'd0, ms};
        res  = (full >> d) << 3;
`endif
        v.e_small = res[26:0];
        v.e_lat   = 1 + (d + 3) / 4;
        return v;
    endfunction

    task automatic drive_ops(input vec_t v);
        in_exp_A = v.exp_a; in_exp_B = v.exp_b; in_code = v.code;
        in_mant_A = v.mant_a; in_mant_B = v.mant_b;
    endtask

    task automatic scramble_ops();
        in_exp_A  = 8'($urandom_range(0, 255));
        in_exp_B  = 8'($urandom_range(0, 255));
        in_code   = 2'($urandom_range(0, 3));
        in_mant_A = 24'($urandom_range(0, 24'hFFFFFF));
        in_mant_B = 24'($urandom_range(0, 24'hFFFFFF));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!out_ready && n < 20) begin
            @(posedge in_clk); #1; n++;
        end
        check("ready_before_accept", 64'(out_ready), 64'd1);
    endtask

    // Driver + scoreboard: push at accept, pop and compare once out_valid appears.
    task automatic run_op(input vec_t v, input int hold, input bit bp);
        int lat;
        int el;
        logic [62:0] e;
        wait_ready();
        drive_ops(v);
        in_valid = 1'b1;
        exp_q.push_back({v.e_exp, v.e_swap, v.e_big, v.e_small});
        lat_q.push_back(v.e_lat);
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        scramble_ops();
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge in_clk); #1; lat++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check("latency", 64'(lat), 64'(el));
        check("out_exp", 64'(out_exp), 64'(e[62:55]));
        check("out_swap", 64'(out_swap), 64'(e[54]));
        check("out_mant_big", 64'(out_mant_big), 64'(e[53:27]));
        check("out_mant_small", 64'(out_mant_small), 64'(e[26:0]));
        for (int i = 0; i < hold; i++) begin
            if (bp) begin
                in_valid = 1'b1;
                scramble_ops();
            end
            @(posedge in_clk); #1;
            if (bp) begin
                check("bp_valid_held", 64'(out_valid), 64'd1);
                check("bp_ready_low", 64'(out_ready), 64'd0);
                check("bp_exp_stable", 64'(out_exp), 64'(e[62:55]));
                check("bp_small_stable", 64'(out_mant_small), 64'(e[26:0]));
                check("bp_big_stable", 64'(out_mant_big), 64'(e[53:27]));
            end
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge in_clk); #1;
        in_ready = 1'b0;
        check("valid_dropped", 64'(out_valid), 64'd0);
        if (bp) begin
            check("bp_idle_ready", 64'(out_ready), 64'd1);
            check("bp_idle_state", 64'(dbg_state), 64'(IDLE));
        end
    endtask

    initial begin
        int  d;
        bit  stale;
        logic [7:0] ea, eb;
        logic [1:0] c;

        tbl[0] = mk(8'h80, 8'h80, 2'b00, 24'h800000, 24'hC00000, 8'h80, 1'b0, 27'h4000000, 27'h6000000, 27'h6000000, 1);
        tbl[1] = mk(8'h7B, 8'h80, 2'b01, 24'h800001, 24'h800000, 8'h80, 1'b1, 27'h4000000, 27'h0200001, 27'h0200000, 3);
        tbl[2] = mk(8'hA8, 8'h80, 2'b10, 24'h800000, 24'hFFFFFF, 8'hA8, 1'b0, 27'h4000000, 27'h0000001, 27'h0000000, 8);
        tbl[3] = mk(8'h85, 8'h81, 2'b11, 24'hABCDEF, 24'h900000, 8'h85, 1'b0, 27'h55E6F78, 27'h0480000, 27'h0480000, 2);
        tbl[4] = mk(8'h80, 8'h9B, 2'b01, 24'hFFFFFF, 24'h800000, 8'h9B, 1'b1, 27'h4000000, 27'h0000001, 27'h0000000, 8);
        tbl[5] = mk(8'h99, 8'h80, 2'b10, 24'h800000, 24'hFFFFFF, 8'h99, 1'b0, 27'h4000000, 27'h0000003, 27'h0000000, 8);
        tbl[6] = mk(8'h81, 8'h80, 2'b10, 24'hC00000, 24'h800001, 8'h81, 1'b0, 27'h6000000, 27'h2000004, 27'h2000000, 2);
        tbl[7] = mk(8'h70, 8'h78, 2'b01, 24'h8000FF, 24'hFFFFFF, 8'h78, 1'b1, 27'h7FFFFF8, 27'h0040007, 27'h0040000, 3);

        // reset: no accept while in_rst is high, even with in_valid asserted
        in_rst = 1'b1; in_valid = 1'b1; in_ready = 1'b0;
        drive_ops(tbl[0]);
        #1;
        check("reset_ready_low", 64'(out_ready), 64'd0);
        @(posedge in_clk); #1;
        @(posedge in_clk); #1;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_exp", 64'(out_exp), 64'd0);
        check("reset_swap", 64'(out_swap), 64'd0);
        check("reset_big", 64'(out_mant_big), 64'd0);
        check("reset_small", 64'(out_mant_small), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        in_valid = 1'b0;
        in_rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(out_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_op(tbl[i], $urandom_range(0, 2), 1'b0);

        for (int i = 0; i < 10; i++) begin
            ea = 8'($urandom_range(40, 200));
            d  = $urandom_range(0, 35);
            eb = ($urandom_range(0, 1) == 1) ? ea + 8'(d) : ea - 8'(d);
            if (ea == eb)     c = 2'b00;
            else if (ea < eb) c = 2'b01;
            else              c = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
            run_op(model(ea, eb, c, {1'b1, 23'($urandom_range(0, 23'h7FFFFF))},
                         {1'b1, 23'($urandom_range(0, 23'h7FFFFF))}), 0, 1'b0);
        end

        // backpressure: in_ready low for 4 cycles in DONE with competing in_valid
        run_op(tbl[1], 4, 1'b1);

        // reset during SHIFT aborts the operation
        wait_ready();
        drive_ops(tbl[4]);
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        @(posedge in_clk); #1;
        @(posedge in_clk); #1;
        check("midop_in_shift", 64'(dbg_state), 64'(SHIFT));
        in_rst = 1'b1;
        #1;
        check("midop_ready_in_reset", 64'(out_ready), 64'd0);
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        check("midop_valid", 64'(out_valid), 64'd0);
        check("midop_exp", 64'(out_exp), 64'd0);
        check("midop_swap", 64'(out_swap), 64'd0);
        check("midop_big", 64'(out_mant_big), 64'd0);
        check("midop_small", 64'(out_mant_small), 64'd0);
        #1;
        check("midop_ready_after", 64'(out_ready), 64'd1);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge in_clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("midop_no_stale_valid", 64'(stale), 64'd0);

        run_op(tbl[6], 0, 1'b0);
        run_op(tbl[0], 1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
